// File: rtl/operand_loader_if.sv
// Bundle for the operand loader's word stream, triple output and status.
// The loader uses the slave modport; the producer/consumer side uses master.
interface operand_loader_if #(
    parameter int DATAWIDTH = 32,
    parameter int CNTWIDTH  = 16
);
    logic [DATAWIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_first;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic [DATAWIDTH-1:0] c;
    logic                 out_valid;
    logic                 out_ready;
    logic                 sync_err;
    logic                 err_clr;
    logic [CNTWIDTH-1:0]  out_count;

    modport master (
        output in_data, in_valid, in_first, out_ready, err_clr,
        input  in_ready, a, b, c, out_valid, sync_err, out_count
    );

    modport slave (
        input  in_data, in_valid, in_first, out_ready, err_clr,
        output in_ready, a, b, c, out_valid, sync_err, out_count
    );
endinterface

// File: rtl/operand_loader.sv
// Collects a serial word stream into an {a, b, c} triple and holds it on
// registered outputs until the datapath consumes it.
module operand_loader #(
    parameter int DATAWIDTH = 32,
    parameter int CNTWIDTH  = 16
) (
    input logic             Clk,
    input logic             Rst,
    operand_loader_if.slave bus
);
    localparam logic [1:0] LOAD_A  = 2'd0;
    localparam logic [1:0] LOAD_B  = 2'd1;
    localparam logic [1:0] LOAD_C  = 2'd2;
    localparam logic [1:0] PRESENT = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [DATAWIDTH-1:0] a_q, a_d;
    logic [DATAWIDTH-1:0] b_q, b_d;
    logic [DATAWIDTH-1:0] c_q, c_d;
    logic [CNTWIDTH-1:0]  outCount_q, outCount_d;
    logic                 syncErr_q, syncErr_d;
    logic                 errSet;

    // A first-marked word arriving mid-triple restarts the triple with that
    // word as the new operand a, so the stream re-locks without losing it.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        outCount_d = outCount_q;
        errSet     = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (bus.in_valid) begin
                    if (bus.in_first) begin
                        a_d     = bus.in_data;
                        state_d = LOAD_B;
                    end else begin
                        errSet = 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (bus.in_valid) begin
                    if (bus.in_first) begin
                        a_d    = bus.in_data;
                        errSet = 1'b1;
                    end else begin
                        b_d     = bus.in_data;
                        state_d = LOAD_C;
                    end
                end
            end
            LOAD_C: begin
                if (bus.in_valid) begin
                    if (bus.in_first) begin
                        a_d     = bus.in_data;
                        errSet  = 1'b1;
                        state_d = LOAD_B;
                    end else begin
                        c_d     = bus.in_data;
                        state_d = PRESENT;
                    end
                end
            end
            default: begin
                if (bus.out_ready) begin
                    outCount_d = outCount_q + 1'b1;
                    state_d    = LOAD_A;
                end
            end
        endcase
        // A new framing error takes priority over a coincident clear.
        syncErr_d = errSet | (syncErr_q & ~bus.err_clr);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= LOAD_A;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            outCount_q <= '0;
            syncErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            outCount_q <= outCount_d;
            syncErr_q  <= syncErr_d;
        end
    end

    assign bus.in_ready  = (state_q != PRESENT);
    assign bus.out_valid = (state_q == PRESENT);
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.c         = c_q;
    assign bus.sync_err  = syncErr_q;
    assign bus.out_count = outCount_q;
endmodule

// File: tb/tb_operand_loader.sv
// Checks operand_loader against a queue-based model of triple assembly,
// using directed scenarios followed by randomized traffic.
module tb_operand_loader;
    localparam int DW = 32;
    localparam int CW = 4;

    logic Clk;
    logic Rst;
    int   checkCount;
    int   failCount;

    operand_loader_if #(.DATAWIDTH(DW), .CNTWIDTH(CW)) bus ();

    operand_loader #(.DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Model: operands collected so far for the current triple; three means
    // the triple is on display and waiting for the consumer.
    logic [DW-1:0] pend[$];
    logic [DW-1:0] mA, mB, mC;
    logic          mErr;
    int            mCount;

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        pend.delete();
        mA = '0;
        mB = '0;
        mC = '0;
        mErr = 1'b0;
        mCount = 0;
    endtask

    task automatic modelEdge(input logic v, input logic f, input logic [DW-1:0] d,
                             input logic ordy, input logic clr, input logic rst);
        logic errNew;
        errNew = 1'b0;
        if (rst) begin
            modelReset();
            return;
        end
        if (pend.size() == 3) begin
            if (ordy) begin
                mCount = (mCount + 1) % (1 << CW);
                pend.delete();
            end
        end else if (v) begin
            if (f) begin
                if (pend.size() != 0) errNew = 1'b1;
                pend.delete();
                pend.push_back(d);
                mA = d;
            end else if (pend.size() == 0) begin
                errNew = 1'b1;
            end else begin
                pend.push_back(d);
                if (pend.size() == 2) mB = d;
                else mC = d;
            end
        end
        mErr = errNew | (mErr & ~clr);
    endtask

    // Drive inputs away from the edge, let the edge happen, then compare
    // every output with the model on the following falling edge.
    task automatic applyStimulus(input logic v, input logic f, input logic [DW-1:0] d,
                                 input logic ordy, input logic clr, input logic rst);
        bus.in_valid  = v;
        bus.in_first  = f;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.err_clr   = clr;
        Rst           = rst;
        @(posedge Clk);
        modelEdge(v, f, d, ordy, clr, rst);
        @(negedge Clk);
        checkOutput("a", bus.a, mA);
        checkOutput("b", bus.b, mB);
        checkOutput("c", bus.c, mC);
        checkOutput("out_valid", DW'(bus.out_valid), DW'(pend.size() == 3));
        checkOutput("in_ready", DW'(bus.in_ready), DW'(pend.size() < 3));
        checkOutput("sync_err", DW'(bus.sync_err), DW'(mErr));
        checkOutput("out_count", DW'(bus.out_count), DW'(mCount));
    endtask

    task automatic sendWord(input logic [DW-1:0] d, input logic f, input logic ordy);
        applyStimulus(1'b1, f, d, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        modelReset();

        // Reset held two cycles with a word offered.
        applyStimulus(1'b1, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1);

        // Nominal triple with the consumer always ready.
        sendWord(32'h5, 1'b1, 1'b1);
        sendWord(32'h3, 1'b0, 1'b1);
        sendWord(32'h7, 1'b0, 1'b1);
        checkOutput("nominal_a", bus.a, 32'h5);
        checkOutput("nominal_c", bus.c, 32'h7);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("nominal_count", DW'(bus.out_count), 32'd1);

        // Backpressure: triple held while words are offered.
        sendWord(32'h1, 1'b1, 1'b0);
        sendWord(32'h2, 1'b0, 1'b0);
        sendWord(32'h3, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) sendWord(32'hF0 + i, 1'b0, 1'b0);
        checkOutput("bp_b", bus.b, 32'h2);
        applyStimulus(1'b1, 1'b1, 32'hEE, 1'b1, 1'b0, 1'b0);
        sendWord(32'h44, 1'b1, 1'b0);
        checkOutput("bp_next_a", bus.a, 32'h44);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Framing errors, resync and error clearing.
        sendWord(32'hAA, 1'b0, 1'b0);
        checkOutput("frame_err", DW'(bus.sync_err), 32'd1);
        sendWord(32'h1, 1'b1, 1'b0);
        sendWord(32'h2, 1'b0, 1'b0);
        sendWord(32'h9, 1'b1, 1'b0);
        sendWord(32'h4, 1'b0, 1'b0);
        sendWord(32'h6, 1'b0, 1'b0);
        checkOutput("frame_a", bus.a, 32'h9);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        checkOutput("clr_err", DW'(bus.sync_err), 32'd0);
        sendWord(32'hBB, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'hCC, 1'b0, 1'b1, 1'b0);
        checkOutput("set_wins", DW'(bus.sync_err), 32'd1);

        // Counter wrap over 17 back-to-back triples.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            sendWord(DW'(k), 1'b1, 1'b1);
            sendWord(DW'(k * 3), 1'b0, 1'b1);
            sendWord(DW'(k * 7), 1'b0, 1'b1);
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
            checkOutput("wrap_count", DW'(bus.out_count), DW'(k % 16));
        end

        // Reset mid-triple and while presenting.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        sendWord(32'hA1, 1'b1, 1'b0);
        sendWord(32'hB2, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'hC3, 1'b1, 1'b0, 1'b1);
        sendWord(32'hA1, 1'b1, 1'b0);
        sendWord(32'hB2, 1'b0, 1'b0);
        sendWord(32'hC3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        checkOutput("midrst_valid", DW'(bus.out_valid), 32'd0);
        checkOutput("midrst_count", DW'(bus.out_count), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), $urandom(),
                          ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule
